// File: rtl/evm_sched_pkg.sv
// ---------------------------------------------------------------------------
// evm_sched_pkg
//   Shared types and helpers for the EVM booth scheduler.
//   - sched_state_e  : scheduler FSM states
//   - CAND_*         : 2-bit booth candidate codes (0 = invalid request)
//   - cand_to_onehot : maps a candidate code onto the core's three
//                      vote_candidate_N strobes
// ---------------------------------------------------------------------------
package evm_sched_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        POWER_ON = 3'd1,
        READY    = 3'd2,
        VOTE     = 3'd3,
        WAIT     = 3'd4,
        CLOSE    = 3'd5,
        CLOSING  = 3'd6
    } sched_state_e;

    localparam logic [1:0] CAND_NONE = 2'd0;
    localparam logic [1:0] CAND_1    = 2'd1;
    localparam logic [1:0] CAND_2    = 2'd2;
    localparam logic [1:0] CAND_3    = 2'd3;

    // Code 1..3 selects vote_candidate_1..3; the invalid code yields no strobe.
    function automatic logic [2:0] cand_to_onehot(input logic [1:0] cand);
        logic [2:0] onehot;
        onehot = 3'b000;
        case (cand)
            CAND_1:  onehot = 3'b001;
            CAND_2:  onehot = 3'b010;
            CAND_3:  onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/evm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// evm_rr_arbiter
//   Round-robin arbiter. Grants the first requester at or after the rotating
//   pointer. The pointer only moves when the caller actually consumes the
//   grant (adv=1), and then lands just past the winner.
// Ports
//   clk         in   clock
//   rst         in   asynchronous active-low reset (pointer -> 0)
//   req         in   N request lines
//   adv         in   grant consumed this cycle; advance the pointer
//   grant       out  one-hot grant (all zero when nobody requests)
//   grant_idx   out  binary index of the granted requester
//   grant_valid out  some requester is granted
// ---------------------------------------------------------------------------
module evm_rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 adv,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr;
    int               idx;

    // Walk the requesters from the pointer backwards-in-priority so the
    // last hit written is the one closest to the pointer.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[IDX_W'(idx)]) begin
                grant               = '0;
                grant[IDX_W'(idx)]  = 1'b1;
                grant_idx           = IDX_W'(idx);
                grant_valid         = 1'b1;
            end
        end
    end

    // Pointer moves to winner+1 (mod N), wrapping explicitly so N need not
    // be a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (adv && grant_valid) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/evm_booth_scheduler.sv
// ---------------------------------------------------------------------------
// evm_booth_scheduler
//   Shares one EVM voting core between NUM_BOOTHS booth requesters: powers
//   the core, arbitrates booth votes round-robin, turns each accepted vote
//   into a single-cycle vote strobe, then closes the session and waits for
//   the core's voting_done (with a timeout).
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   session_start/end  session control pulses
//   booth_req/cand     per-booth request and 2-bit candidate code
//   booth_ack/nack     per-booth accept / reject (invalid code) pulses
//   evm_switch_on      core switch_on_evm
//   evm_cand_ready     core candidate_ready
//   evm_vote           core vote_candidate_1..3 (one-hot pulse)
//   evm_session_done   core voting_session_done
//   evm_voting_done    core voting_done
//   busy               scheduler not idle
//   timeout_err        sticky: core never reported voting_done in time
//   votes_accepted     saturating count of votes issued this session
// Configuration
//   EVM_SCHED_BOOTH_LOCK_EN : when defined, a granted booth cannot be
//   granted again until its request has dropped for at least one cycle.
// ---------------------------------------------------------------------------
module evm_booth_scheduler
    import evm_sched_pkg::*;
#(
    parameter int NUM_BOOTHS   = 4,
    parameter int VOTE_GAP     = 4,
    parameter int DONE_TIMEOUT = 64,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    session_start,
    input  logic                    session_end,
    input  logic [NUM_BOOTHS-1:0]   booth_req,
    input  logic [2*NUM_BOOTHS-1:0] booth_cand,
    output logic [NUM_BOOTHS-1:0]   booth_ack,
    output logic [NUM_BOOTHS-1:0]   booth_nack,
    output logic                    evm_switch_on,
    output logic                    evm_cand_ready,
    output logic [2:0]              evm_vote,
    output logic                    evm_session_done,
    input  logic                    evm_voting_done,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [CNT_W-1:0]        votes_accepted
);

    localparam int IDX_W   = $clog2(NUM_BOOTHS);
    localparam int TMR_MAX = (VOTE_GAP > DONE_TIMEOUT) ? VOTE_GAP : DONE_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    sched_state_e          state;
    sched_state_e          state_next;
    logic                  end_pending;
    logic                  end_req;
    logic [1:0]            cand_hold;
    logic [1:0]            grant_cand;
    logic [TMR_W-1:0]      tmr;
    logic [NUM_BOOTHS-1:0] arb_req;
    logic [NUM_BOOTHS-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  take_grant;

    // A session_end arriving in the same READY cycle counts as pending.
    assign end_req    = end_pending | session_end;
    assign take_grant = (state == READY) && !end_req && grant_valid;
    assign grant_cand = booth_cand[{grant_idx, 1'b0} +: 2];

`ifdef EVM_SCHED_BOOTH_LOCK_EN
    logic [NUM_BOOTHS-1:0] lock;

    assign arb_req = booth_req & ~lock;

    // A lock survives only while the booth keeps its request high, so one
    // low cycle releases it; newly granted booths are locked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock <= '0;
        end else if (state == IDLE && session_start) begin
            lock <= '0;
        end else begin
            lock <= (lock & booth_req) | (take_grant ? grant : '0);
        end
    end
`else
    assign arb_req = booth_req;
`endif

    evm_rr_arbiter #(
        .N (NUM_BOOTHS)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (arb_req),
        .adv         (take_grant),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and core/booth strobes. Acks are combinational so a booth
    // sees acceptance in the very cycle its request is arbitrated.
    always_comb begin
        state_next       = state;
        booth_ack        = '0;
        booth_nack       = '0;
        evm_switch_on    = 1'b1;
        evm_cand_ready   = 1'b0;
        evm_vote         = 3'b000;
        evm_session_done = 1'b0;
        busy             = 1'b1;
        case (state)
            IDLE: begin
                evm_switch_on = 1'b0;
                busy          = 1'b0;
                if (session_start) begin
                    state_next = POWER_ON;
                end
            end
            POWER_ON: begin
                state_next = READY;
            end
            READY: begin
                evm_cand_ready = 1'b1;
                if (end_req) begin
                    state_next = CLOSE;
                end else if (grant_valid) begin
                    if (grant_cand != CAND_NONE) begin
                        booth_ack  = grant;
                        state_next = VOTE;
                    end else begin
                        booth_nack = grant;
                    end
                end
            end
            VOTE: begin
                evm_vote   = cand_to_onehot(cand_hold);
                state_next = WAIT;
            end
            WAIT: begin
                if (tmr == '0) begin
                    state_next = READY;
                end
            end
            CLOSE: begin
                evm_session_done = 1'b1;
                state_next       = CLOSING;
            end
            CLOSING: begin
                if (evm_voting_done || tmr == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Remember a session_end seen mid-session until CLOSE consumes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            end_pending <= 1'b0;
        end else if (state == IDLE || state == CLOSE) begin
            end_pending <= 1'b0;
        end else if (session_end) begin
            end_pending <= 1'b1;
        end
    end

    // Candidate is captured at grant time so the booth may change its code
    // (or drop its request) while the vote is still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_hold <= CAND_NONE;
        end else if (take_grant) begin
            cand_hold <= grant_cand;
        end
    end

    // One down-counter serves both the post-vote gap and the close timeout;
    // it is loaded on the cycle before the state that consumes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (state == VOTE) begin
            tmr <= TMR_W'(VOTE_GAP - 1);
        end else if (state == CLOSE) begin
            tmr <= TMR_W'(DONE_TIMEOUT - 1);
        end else if ((state == WAIT || state == CLOSING) && tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    // Session bookkeeping: vote count and sticky timeout flag, both cleared
    // when a new session is opened.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            votes_accepted <= '0;
            timeout_err    <= 1'b0;
        end else begin
            if (state == IDLE && session_start) begin
                votes_accepted <= '0;
                timeout_err    <= 1'b0;
            end
            if (state == VOTE && votes_accepted != '1) begin
                votes_accepted <= votes_accepted + 1'b1;
            end
            if (state == CLOSING && !evm_voting_done && tmr == '0) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_evm_booth_scheduler.sv
// ---------------------------------------------------------------------------
// tb_evm_booth_scheduler
//   Scoreboard bench for evm_booth_scheduler (default parameters). Expected
//   grants and votes are queued as requests are driven and retired by a
//   monitor whenever the scheduler acks/nacks a booth.
// ---------------------------------------------------------------------------
module tb_evm_booth_scheduler;

    localparam int N   = 4;
    localparam int GAP = 4;
    localparam int TO  = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           session_start = 1'b0;
    logic           session_end = 1'b0;
    logic           evm_voting_done = 1'b0;
    logic [N-1:0]   booth_req = '0;
    logic [2*N-1:0] booth_cand = '0;
    logic [N-1:0]   booth_ack;
    logic [N-1:0]   booth_nack;
    logic           evm_switch_on;
    logic           evm_cand_ready;
    logic [2:0]     evm_vote;
    logic           evm_session_done;
    logic           busy;
    logic           timeout_err;
    logic [7:0]     votes_accepted;

    typedef struct {
        logic [N-1:0] ack;
        logic [N-1:0] nack;
        logic [2:0]   vote;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    evm_booth_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .session_start    (session_start),
        .session_end      (session_end),
        .booth_req        (booth_req),
        .booth_cand       (booth_cand),
        .booth_ack        (booth_ack),
        .booth_nack       (booth_nack),
        .evm_switch_on    (evm_switch_on),
        .evm_cand_ready   (evm_cand_ready),
        .evm_vote         (evm_vote),
        .evm_session_done (evm_session_done),
        .evm_voting_done  (evm_voting_done),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .votes_accepted   (votes_accepted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic [2*N-1:0] cand);
        @(posedge clk);
        #1;
        booth_req  = req;
        booth_cand = cand;
    endtask

    task automatic pushExp(input logic [N-1:0] ack, input logic [N-1:0] nack, input logic [2:0] vote);
        exp_t e;
        e.ack  = ack;
        e.nack = nack;
        e.vote = vote;
        exp_q.push_back(e);
    endtask

    task automatic waitAck(input string tag, input int budget, output int at_cyc);
        bit found;
        found  = 1'b0;
        at_cyc = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (booth_ack != '0 || booth_nack != '0) begin
                found  = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        if (!found) checkOutput({tag, "_ack_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic waitSessionDone(input string tag, input int budget, output int at_cyc);
        bit found;
        found  = 1'b0;
        at_cyc = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (evm_session_done) begin
                found  = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        if (!found) checkOutput({tag, "_done_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic startSession(input string tag);
        @(posedge clk);
        #1 session_start = 1'b1;
        @(posedge clk);
        #1 session_start = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_switch_on"}, 32'(evm_switch_on), 32'(1));
        checkOutput({tag, "_votes_clr"}, 32'(votes_accepted), 32'(0));
        checkOutput({tag, "_terr_clr"}, 32'(timeout_err), 32'(0));
    endtask

    // Scoreboard monitor: every ack/nack retires the oldest expectation; an
    // ack additionally obliges a matching vote strobe on the next cycle.
    initial begin : monitor
        exp_t       e;
        logic       vote_pending;
        logic [2:0] pend_vote;
        vote_pending = 1'b0;
        pend_vote    = 3'b000;
        forever begin
            @(negedge clk);
            if (vote_pending) begin
                checkOutput("evm_vote", 32'(evm_vote), 32'(pend_vote));
                vote_pending = 1'b0;
            end else if (evm_vote != 3'b000) begin
                checkOutput("spurious_vote", 32'(evm_vote), 32'(0));
            end
            if (booth_ack != '0 || booth_nack != '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_grant", 32'({booth_ack, booth_nack}), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("booth_ack", 32'(booth_ack), 32'(e.ack));
                    checkOutput("booth_nack", 32'(booth_nack), 32'(e.nack));
                    if (e.ack != '0) begin
                        vote_pending = 1'b1;
                        pend_vote    = e.vote;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int t0;
        int t1;
        int gcyc[4];
        int nacks;
        bit idle_seen;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_switch_on", 32'(evm_switch_on), 32'(0));
        checkOutput("rst_votes", 32'(votes_accepted), 32'(0));
        checkOutput("rst_terr", 32'(timeout_err), 32'(0));
        checkOutput("rst_acks", 32'({booth_ack, booth_nack}), 32'(0));
        @(posedge clk);
        #1 rst = 1'b1;

        // Single vote: booth0 candidate 2
        startSession("s1");
        pushExp(4'b0001, 4'b0000, 3'b010);
        applyStimulus(4'b0001, 8'h02);
        waitAck("t1", 10, t0);
        applyStimulus(4'b0000, 8'h00);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1_votes", 32'(votes_accepted), 32'(1));
        checkOutput("t1_wait_nready", 32'(evm_cand_ready), 32'(0));

        // Reset while the second vote is on the core interface
        pushExp(4'b0100, 4'b0000, 3'b100);
        applyStimulus(4'b0100, 8'h30);
        waitAck("t6", 20, t0);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("t6_vote", 32'(evm_vote), 32'(0));
        checkOutput("t6_switch_on", 32'(evm_switch_on), 32'(0));
        checkOutput("t6_busy", 32'(busy), 32'(0));
        checkOutput("t6_votes", 32'(votes_accepted), 32'(0));
        checkOutput("t6_ready", 32'(evm_cand_ready), 32'(0));
        booth_req  = '0;
        booth_cand = '0;
        @(posedge clk);
        #1 rst = 1'b1;

        // Held requests from booths 0,1,3 (pointer starts at 0 after reset)
        startSession("s2");
        pushExp(4'b0001, 4'b0000, 3'b001);
        pushExp(4'b0010, 4'b0000, 3'b001);
        pushExp(4'b1000, 4'b0000, 3'b001);
        pushExp(4'b0001, 4'b0000, 3'b001);
        applyStimulus(4'b1011, 8'h55);
        for (int i = 0; i < 4; i++) begin
            waitAck("t2", 20, gcyc[i]);
        end
        for (int i = 1; i < 4; i++) begin
            checkOutput("t2_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'(GAP + 2));
        end

        // Invalid code from booth2 -> nack, then pointer must sit at 3
        pushExp(4'b0000, 4'b0100, 3'b000);
        applyStimulus(4'b0100, 8'h00);
        waitAck("t3", 20, t0);
        applyStimulus(4'b0000, 8'h00);
        @(negedge clk);
        checkOutput("t3_stay_ready", 32'(evm_cand_ready), 32'(1));
        checkOutput("t3_votes", 32'(votes_accepted), 32'(4));
        pushExp(4'b1000, 4'b0000, 3'b100);
        applyStimulus(4'b1001, 8'hC1);
        waitAck("t3b", 10, t0);

        // session_end during WAIT; core reports done after 5 cycles
        applyStimulus(4'b0000, 8'h00);
        @(posedge clk);
        #1 session_end = 1'b1;
        @(posedge clk);
        #1 session_end = 1'b0;
        waitSessionDone("t4", 20, t0);
        checkOutput("t4_votes", 32'(votes_accepted), 32'(5));
        @(negedge clk);
        checkOutput("t4_done_width", 32'(evm_session_done), 32'(0));
        checkOutput("t4_closing_on", 32'(evm_switch_on), 32'(1));
        repeat (4) @(posedge clk);
        #1 evm_voting_done = 1'b1;
        @(posedge clk);
        #1 evm_voting_done = 1'b0;
        @(negedge clk);
        checkOutput("t4_busy", 32'(busy), 32'(0));
        checkOutput("t4_switch_off", 32'(evm_switch_on), 32'(0));
        checkOutput("t4_terr", 32'(timeout_err), 32'(0));

        // Close with no voting_done -> timeout after DONE_TIMEOUT cycles
        startSession("s3");
        @(posedge clk);
        #1 session_end = 1'b1;
        @(posedge clk);
        #1 session_end = 1'b0;
        waitSessionDone("t5", 10, t0);
        idle_seen = 1'b0;
        t1 = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) begin
                idle_seen = 1'b1;
                t1 = cyc;
                break;
            end
        end
        checkOutput("t5_idle_seen", 32'(idle_seen), 32'(1));
        checkOutput("t5_timeout_len", 32'(t1 - t0), 32'(TO + 1));
        checkOutput("t5_terr", 32'(timeout_err), 32'(1));
        checkOutput("t5_switch_off", 32'(evm_switch_on), 32'(0));
        startSession("s4");

`ifdef EVM_SCHED_BOOTH_LOCK_EN
        // Held booth1 across several ballot windows gets a single ack
        pushExp(4'b0010, 4'b0000, 3'b010);
        applyStimulus(4'b0010, 8'h08);
        nacks = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (booth_ack[1]) nacks++;
        end
        checkOutput("lock_acks", 32'(nacks), 32'(1));
        applyStimulus(4'b0000, 8'h00);
`else
        nacks = 0;
`endif

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
